icache_responder: RTL and testbench



---
 rtl/icache_responder.sv | 85 ++++++++
 tb/tb_icache_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped one-word-per-line fetch cache with req/ack refill; define ICACHE_STATS_EN for hit/miss counters
module icache_responder #(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES),
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_address,
  input  logic        flush,
  output logic [31:0] instruction,
  output logic        stall_f,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int TAG_W = 30 - IDX_W;
  typedef enum logic [1:0] {LOOKUP, REFILL, FILL} state_t;
  state_t state, state_nx;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0] data [LINES];
  logic [IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0] tag_in, fill_tag;
  logic drop, hit, miss, fill_ok, unused_lsb;
  assign idx = instr_address[IDX_W+1:2];
  assign tag_in = instr_address[31:IDX_W+2];
  assign fill_idx = mem_addr[IDX_W+1:2];
  assign fill_tag = mem_addr[31:IDX_W+2];
  assign unused_lsb = ^instr_address[1:0];
  assign hit = state == LOOKUP && valid[idx] && tags[idx] == tag_in;
  assign miss = state == LOOKUP && !hit;
  assign instruction = hit ? data[idx] : NOP_WORD;
  assign stall_f = !hit;
  assign fill_ok = state == REFILL && mem_ack && !drop && !flush;
  always_comb begin
    state_nx = state == LOOKUP ? (hit ? LOOKUP : REFILL)
             : state == REFILL ? (mem_ack ? FILL : REFILL)
             : LOOKUP;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOOKUP;
      valid <= '0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      drop <= 1'b0;
    end else begin
      state <= state_nx;
      drop <= state == REFILL && !mem_ack && (drop || flush);
      if (flush)
        valid <= '0;
      else if (fill_ok)
        valid[fill_idx] <= 1'b1;
      if (miss) begin
        mem_req <= 1'b1;
        mem_addr <= {instr_address[31:2], 2'b00};
      end else if (state == REFILL && mem_ack)
        mem_req <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (fill_ok) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= mem_rdata;
    end
  end
`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      hit_count <= hit ? hit_count + 32'd1 : hit_count;
      miss_count <= miss ? miss_count + 32'd1 : miss_count;
    end
  end
`endif
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: randomized self-checking bench against a line-level direct-mapped cache model
module tb_icache_responder;
  localparam int LINES = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, mem_ack = 1'b0;
  logic [31:0] instr_address = '0, mem_rdata = '0;
  logic [31:0] instruction, mem_addr;
  logic stall_f, mem_req;
  int n_checks = 0, n_pass = 0;
  bit seen_bad = 1'b0;
  bit ref_valid [LINES];
  logic [29:0] ref_word [LINES];
  logic [31:0] ref_data [LINES];
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
  int m_hits = 0, m_miss = 0;
`endif
  icache_responder dut (
    .clk(clk),
    .rst_n(rst_n),
    .instr_address(instr_address),
    .flush(flush),
    .instruction(instruction),
    .stall_f(stall_f),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (instruction == 32'hDEADBEEF) seen_bad = 1'b1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic int ix(input logic [31:0] a);
    return int'((a >> 2) % 32'(LINES));
  endfunction
  function automatic bit model_hit(input logic [31:0] a);
    return ref_valid[ix(a)] && ref_word[ix(a)] == a[31:2];
  endfunction
  task automatic model_clear();
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
  endtask
  task automatic access(input logic [31:0] a, input int lat, input logic [31:0] w, input int fc, input logic [31:0] rd);
    int st;
    instr_address = a;
    if (model_hit(a)) begin
      flush = fc != 0;
      mem_ack = $urandom_range(0, 3) == 0;
      mem_rdata = $urandom;
      @(negedge clk);
      check("hit_stall", 32'(stall_f), 32'd0);
      check("hit_data", instruction, ref_data[ix(a)]);
      check("hit_req", 32'(mem_req), 32'd0);
`ifdef ICACHE_STATS_EN
      m_hits++;
`endif
      @(posedge clk); #1;
      flush = 1'b0;
      mem_ack = 1'b0;
      if (fc != 0) model_clear();
      return;
    end
    @(negedge clk);
    check("miss_nop", instruction, NOP);
    check("miss_idle_req", 32'(mem_req), 32'd0);
    st = int'(stall_f);
`ifdef ICACHE_STATS_EN
    m_miss++;
`endif
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk); #1;
      if (i == 1 && rd != a) instr_address = rd;
      flush = fc == i;
      mem_ack = i == lat;
      mem_rdata = i == lat ? w : $urandom;
      @(negedge clk);
      check("refill_req", 32'(mem_req), 32'd1);
      check("refill_addr", mem_addr, {a[31:2], 2'b00});
      check("refill_nop", instruction, NOP);
      st += int'(stall_f);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    flush = fc == lat + 1;
    @(negedge clk);
    check("fill_req", 32'(mem_req), 32'd0);
    check("fill_nop", instruction, NOP);
    st += int'(stall_f);
    @(posedge clk); #1;
    flush = 1'b0;
    check("penalty", 32'(st), 32'(lat + 2));
    if (fc >= 1 && fc <= lat + 1)
      model_clear();
    else begin
      ref_valid[ix(a)] = 1'b1;
      ref_word[ix(a)] = a[31:2];
      ref_data[ix(a)] = w;
    end
  endtask
  initial begin
    logic [31:0] a;
    int lat, fc;
    model_clear();
    #2;
    check("rst_stall", 32'(stall_f), 32'd1);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_instr", instruction, NOP);
    @(posedge clk); #1;
    rst_n = 1'b1;
    access(32'h0, 3, 32'h0050_0093, 0, 32'h0);
    for (int i = 0; i < 10; i++) access(32'h0, 1, 32'h0, 0, 32'h0);
`ifdef ICACHE_STATS_EN
    check("stats_miss", miss_count, 32'd1);
    check("stats_hit", hit_count, 32'd10);
`endif
    for (int i = 0; i < 16; i++) access(32'(i * 4), $urandom_range(1, 4), $urandom, 0, 32'(i * 4));
    for (int i = 0; i < 16; i++) access(32'(i * 4), 1, 32'h0, 0, 32'(i * 4));
    access(32'h40, 2, $urandom, 0, 32'h40);
    access(32'h0, 2, $urandom, 0, 32'h0);
    access(32'h80, 3, 32'hDEADBEEF, 2, 32'h80);
    access(32'h80, 2, $urandom, 0, 32'h80);
    access(32'hC0, 3, $urandom, 3, 32'hC0);
    access(32'hC0, 2, $urandom, 0, 32'hC0);
    access(32'hC4, 2, $urandom, 3, 32'hC4);
    access(32'hC4, 1, $urandom, 0, 32'hC4);
    access(32'hC4, 1, 32'h0, 1, 32'hC4);
    access(32'hC4, 1, $urandom, 0, 32'hC4);
    access(32'h100, 4, $urandom, 0, 32'h200);
    access(32'h200, 2, $urandom, 0, 32'h200);
    access(32'h100, 1, 32'h0, 0, 32'h100);
    access(32'h200, 1, 32'h0, 0, 32'h200);
    instr_address = 32'h300;
    @(negedge clk);
    check("rr_stall", 32'(stall_f), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rr_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rr_async_req", 32'(mem_req), 32'd0);
    check("rr_async_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
`ifdef ICACHE_STATS_EN
    m_hits = 0;
    m_miss = 0;
`endif
    mem_ack = 1'b1;
    mem_rdata = 32'hBADC_0DE5;
    access(32'h300, 2, $urandom, 0, 32'h300);
    access(32'h300, 1, 32'h0, 0, 32'h300);
    repeat (300) begin
      a = {11'($urandom_range(0, 1)), 19'd0, 2'b00} | 32'($urandom_range(0, 47) * 4);
      lat = $urandom_range(1, 5);
      fc = $urandom_range(0, 7) == 0 ? $urandom_range(1, lat + 1) : 0;
      access(a, lat, $urandom, fc, $urandom_range(0, 5) == 0 ? 32'($urandom_range(0, 47) * 4) : a);
    end
    check("no_deadbeef", 32'(seen_bad), 32'd0);
`ifdef ICACHE_STATS_EN
    check("stats_miss_end", miss_count, 32'(m_miss));
    check("stats_hit_end", hit_count, 32'(m_hits));
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
